// File: rtl/usb_rx_decode.sv
// rtl/usb_rx_decode.sv - full-speed USB receive front end: bit timing, SYNC, NRZI, unstuffing, EOP
module usb_rx_decode #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic d_orig,
    output logic shift_enable,
    output logic crc_clear,
    output logic receiving,
    output logic eop,
    output logic rx_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_RECV,
        S_EOP,
        S_ERR
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          dp_q, dm_q;
    logic          prev_dp, prev_dp_n;
    logic [2:0]    ones_cnt, ones_cnt_n;
    logic [2:0]    zero_cnt, zero_cnt_n;
    logic [1:0]    se0_cnt, se0_cnt_n;
    logic [3:0]    j_cnt, j_cnt_n;
    logic          d_orig_n, shift_n, crc_n, eop_n, rx_error_n, receiving_n;

    logic line_se0, line_se1, line_j, line_k;
    logic resync, strobe, decoded;

    assign line_se0 = ~d_plus & ~d_minus;
    assign line_se1 = d_plus & d_minus;
    assign line_j   = d_plus & ~d_minus;
    assign line_k   = ~d_plus & d_minus;

    // Edges realign the sample point only while a packet is being tracked.
    assign resync  = ((state == S_SYNC) || (state == S_RECV)) && (d_plus != dp_q) && !line_se0;
    assign strobe  = (state != S_IDLE) && (timer == TW'(SAMPLE_PT)) && !resync;
    assign decoded = (d_plus == prev_dp);

    always_comb begin
        timer_n = timer + 1'b1;
        if (state == S_IDLE || resync || timer == TW'(CLKS_PER_BIT - 1))
            timer_n = '0;
    end

    always_comb begin
        state_n    = state;
        prev_dp_n  = prev_dp;
        ones_cnt_n = ones_cnt;
        zero_cnt_n = zero_cnt;
        se0_cnt_n  = se0_cnt;
        j_cnt_n    = j_cnt;
        d_orig_n   = d_orig;
        shift_n    = 1'b0;
        crc_n      = 1'b0;
        eop_n      = 1'b0;

        if (strobe && !line_se0)
            prev_dp_n = d_plus;

        case (state)
            S_IDLE: begin
                ones_cnt_n = '0;
                zero_cnt_n = '0;
                se0_cnt_n  = '0;
                j_cnt_n    = '0;
                if (dp_q && !dm_q && line_k)
                    state_n = S_SYNC;
            end
            S_SYNC: begin
                if (strobe) begin
                    if (line_se0 || line_se1) begin
                        state_n = S_ERR;
                    end else if (!decoded) begin
                        if (zero_cnt == 3'd7)
                            state_n = S_ERR;
                        else
                            zero_cnt_n = zero_cnt + 3'd1;
                    end else if (zero_cnt == 3'd7) begin
                        state_n    = S_RECV;
                        crc_n      = 1'b1;
                        ones_cnt_n = 3'd1;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_RECV: begin
                if (strobe) begin
                    if (line_se0) begin
                        state_n   = S_EOP;
                        se0_cnt_n = 2'd1;
                    end else if (line_se1) begin
                        state_n = S_ERR;
                    end else if (ones_cnt == 3'd6) begin
                        if (decoded)
                            state_n = S_ERR;
                        else
                            ones_cnt_n = '0;
                    end else begin
                        d_orig_n   = decoded;
                        shift_n    = 1'b1;
                        ones_cnt_n = decoded ? ones_cnt + 3'd1 : 3'd0;
                    end
                end
            end
            S_EOP: begin
                if (strobe) begin
                    if (line_se0) begin
                        if (se0_cnt == 2'd3)
                            state_n = S_ERR;
                        else
                            se0_cnt_n = se0_cnt + 2'd1;
                    end else if (line_j) begin
                        eop_n     = 1'b1;
                        state_n   = S_IDLE;
                        prev_dp_n = 1'b1;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (j_cnt == 4'd8) begin
                    state_n   = S_IDLE;
                    prev_dp_n = 1'b1;
                end else if (strobe) begin
                    j_cnt_n = line_j ? j_cnt + 4'd1 : 4'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        rx_error_n  = (state_n == S_ERR) && (state != S_ERR);
        receiving_n = (state_n == S_SYNC) || (state_n == S_RECV) || (state_n == S_EOP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            dp_q         <= 1'b1;
            dm_q         <= 1'b0;
            prev_dp      <= 1'b1;
            ones_cnt     <= '0;
            zero_cnt     <= '0;
            se0_cnt      <= '0;
            j_cnt        <= '0;
            d_orig       <= 1'b0;
            shift_enable <= 1'b0;
            crc_clear    <= 1'b0;
            eop          <= 1'b0;
            rx_error     <= 1'b0;
            receiving    <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            dp_q         <= d_plus;
            dm_q         <= d_minus;
            prev_dp      <= prev_dp_n;
            ones_cnt     <= ones_cnt_n;
            zero_cnt     <= zero_cnt_n;
            se0_cnt      <= se0_cnt_n;
            j_cnt        <= j_cnt_n;
            d_orig       <= d_orig_n;
            shift_enable <= shift_n;
            crc_clear    <= crc_n;
            eop          <= eop_n;
            rx_error     <= rx_error_n;
            receiving    <= receiving_n;
        end
    end

endmodule

// File: tb/tb_usb_rx_decode.sv
// tb/tb_usb_rx_decode.sv - scoreboard bench for usb_rx_decode
module tb_usb_rx_decode;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus, d_minus;
    logic d_orig, shift_enable, crc_clear, receiving, eop, rx_error;

    usb_rx_decode #(.CLKS_PER_BIT(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .crc_clear    (crc_clear),
        .receiving    (receiving),
        .eop          (eop),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int crc_cnt = 0, eop_cnt = 0, err_cnt = 0;
    bit exp_q[$];
    bit lvl = 1'b1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_enable) begin
                chk("shift_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("d_orig", int'(d_orig), int'(exp_q.pop_front()));
            end
            if (crc_clear) crc_cnt++;
            if (eop)       eop_cnt++;
            if (rx_error)  err_cnt++;
        end
    end

    task automatic line(input logic dp, input logic dm, input int n);
        d_plus  = dp;
        d_minus = dm;
        repeat (n) @(negedge clk);
    endtask

    task automatic nrzi(input bit b, input int n);
        if (!b) lvl = ~lvl;
        line(lvl, ~lvl, n);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) nrzi(1'b0, 8);
        nrzi(1'b1, 8);
    endtask

    task automatic send_data(input logic [63:0] v, input int n, input bit jit);
        bit w[$];
        int ones = 1;
        int e_cur = 0;
        int e_nxt;
        for (int i = n - 1; i >= 0; i--) begin
            w.push_back(v[i]);
            exp_q.push_back(v[i]);
            ones = v[i] ? ones + 1 : 0;
            if (ones == 6) begin
                w.push_back(1'b0);
                ones = 0;
            end
        end
        for (int k = 0; k < w.size(); k++) begin
            e_nxt = (jit && k < w.size() - 1) ? int'($urandom_range(2)) - 1 : 0;
            nrzi(w[k], 8 + e_nxt - e_cur);
            e_cur = e_nxt;
        end
    endtask

    task automatic send_eop();
        line(1'b0, 1'b0, 16);
        lvl = 1'b1;
        line(1'b1, 1'b0, 16);
    endtask

    task automatic clr_counts();
        crc_cnt = 0;
        eop_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic good_packet(input string tag);
        clr_counts();
        send_sync();
        send_data(64'hB, 4, 1'b0);
        send_eop();
        chk({tag, "_crc_clear"}, crc_cnt, 1);
        chk({tag, "_eop"}, eop_cnt, 1);
        chk({tag, "_rx_error"}, err_cnt, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_receiving"}, int'(receiving), 0);
    endtask

    initial begin
        logic [63:0] rnd;
        n_rst   = 1'b0;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        #1;
        chk("rst_outputs", int'({d_orig, shift_enable, crc_clear, receiving, eop, rx_error}), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        line(1'b1, 1'b0, 32);
        chk("idle_receiving", int'(receiving), 0);

        // basic packet 1,0,1,1
        clr_counts();
        send_sync();
        chk("sync_receiving", int'(receiving), 1);
        chk("sync_crc_clear", crc_cnt, 1);
        send_data(64'hB, 4, 1'b0);
        send_eop();
        chk("basic_eop", eop_cnt, 1);
        chk("basic_pending", exp_q.size(), 0);
        chk("basic_receiving", int'(receiving), 0);
        chk("basic_rx_error", err_cnt, 0);
        line(1'b1, 1'b0, 16);

        // five 1s after SYNC force a stuffed 0, then data 0
        clr_counts();
        send_sync();
        send_data(64'h3E, 6, 1'b0);
        send_eop();
        chk("stuff_eop", eop_cnt, 1);
        chk("stuff_pending", exp_q.size(), 0);
        chk("stuff_rx_error", err_cnt, 0);
        line(1'b1, 1'b0, 16);

        // seventh consecutive 1 is a stuff violation
        clr_counts();
        send_sync();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(1'b1);
            nrzi(1'b1, 8);
        end
        nrzi(1'b1, 8);
        line(1'b1, 1'b0, 8 * 12);
        chk("stuffviol_rx_error", err_cnt, 1);
        chk("stuffviol_eop", eop_cnt, 0);
        chk("stuffviol_pending", exp_q.size(), 0);
        chk("stuffviol_receiving", int'(receiving), 0);
        lvl = 1'b1;
        good_packet("after_err");
        line(1'b1, 1'b0, 16);

        // truncated SYNC K,J,K,K
        clr_counts();
        nrzi(1'b0, 8);
        nrzi(1'b0, 8);
        nrzi(1'b0, 8);
        nrzi(1'b1, 8);
        line(1'b1, 1'b0, 8 * 12);
        lvl = 1'b1;
        chk("trunc_rx_error", err_cnt, 1);
        chk("trunc_crc_clear", crc_cnt, 0);
        chk("trunc_receiving", int'(receiving), 0);

        // 32 bits with edge jitter
        clr_counts();
        rnd = {32'h0, $urandom()};
        send_sync();
        send_data(rnd, 32, 1'b1);
        send_eop();
        chk("jitter_eop", eop_cnt, 1);
        chk("jitter_rx_error", err_cnt, 0);
        chk("jitter_pending", exp_q.size(), 0);
        line(1'b1, 1'b0, 16);

        // reset mid-RECV
        clr_counts();
        send_sync();
        exp_q.push_back(1'b1); nrzi(1'b1, 8);
        exp_q.push_back(1'b0); nrzi(1'b0, 8);
        exp_q.push_back(1'b1); nrzi(1'b1, 5);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_outputs", int'({d_orig, shift_enable, crc_clear, receiving, eop, rx_error}), 0);
        exp_q.delete();
        lvl = 1'b1;
        line(1'b1, 1'b0, 3);
        n_rst = 1'b1;
        line(1'b1, 1'b0, 16);
        chk("midrst_eop", eop_cnt, 0);
        chk("midrst_rx_error", err_cnt, 0);
        good_packet("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
